// File: rtl/id_issue_queue.sv
`default_nettype none
// =============================================================================
// id_issue_queue : decode-to-execute ring buffer with an integrated RAW/WAW
//                  register scoreboard and a flush that unwinds queued busy bits.
// Optional build macro: ID_ISSUE_WB_BYPASS_EN (same-cycle writeback bypass).
// Revision: 1.0
// =============================================================================
module id_issue_queue #(
    parameter int PAYLOAD_W = 160,
    parameter int DEPTH     = 2,
    parameter int NREG      = 32,
    parameter int RADDR_W   = 5
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [PAYLOAD_W-1:0]       in_payload,
    input  logic [RADDR_W-1:0]         in_rs1,
    input  logic [RADDR_W-1:0]         in_rs2,
    input  logic                       in_rs1_used,
    input  logic                       in_rs2_used,
    input  logic [RADDR_W-1:0]         in_rd,
    input  logic                       in_rd_wr,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [PAYLOAD_W-1:0]       out_payload,
    output logic [RADDR_W-1:0]         out_rd,
    output logic                       out_rd_wr,
    input  logic                       wb_valid,
    input  logic [RADDR_W-1:0]         wb_rd,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       hazard
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [CNT_W-1:0]     count_q, count_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [DEPTH-1:0]     vld_q, vld_d;
    logic [NREG-1:0]      busy_q, busy_d;
    logic [NREG-1:0]      busy_eff;
    logic [PAYLOAD_W-1:0] payload_q [DEPTH];
    logic [RADDR_W-1:0]   rd_q      [DEPTH];
    logic                 rd_wr_q   [DEPTH];
    logic                 enq;
    logic                 deq;

    // Busy view used by the hazard check; the bypass only hides a register
    // that is retiring this very cycle.
    always_comb begin
        busy_eff = busy_q;
`ifdef ID_ISSUE_WB_BYPASS_EN
        if (wb_valid) begin
            busy_eff[wb_rd] = 1'b0;
        end
`endif
    end

    assign hazard    = in_valid & ((in_rs1_used & busy_eff[in_rs1]) |
                                   (in_rs2_used & busy_eff[in_rs2]) |
                                   (in_rd_wr    & busy_eff[in_rd]));
    assign in_ready  = rst_n & ~flush & (count_q != FULL_CNT) & ~hazard;
    assign out_valid = (count_q != '0) & ~flush;
    assign enq       = in_valid & in_ready;
    assign deq       = out_valid & out_ready;

    assign out_payload = payload_q[rd_ptr_q];
    assign out_rd      = rd_q[rd_ptr_q];
    assign out_rd_wr   = rd_wr_q[rd_ptr_q];
    assign count       = count_q;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        vld_d    = vld_q;
        busy_d   = busy_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            vld_d    = '0;
            // Queued rd values are distinct, so releasing each one is exact.
            for (int i = 0; i < DEPTH; i++) begin
                if (vld_q[i] && rd_wr_q[i]) begin
                    busy_d[rd_q[i]] = 1'b0;
                end
            end
        end else begin
            if (enq) begin
                wr_ptr_d        = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
                vld_d[wr_ptr_q] = 1'b1;
            end
            if (deq) begin
                rd_ptr_d        = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
                vld_d[rd_ptr_q] = 1'b0;
            end
            if (enq && !deq) begin
                count_d = count_q + 1'b1;
            end else if (deq && !enq) begin
                count_d = count_q - 1'b1;
            end
        end
        if (wb_valid) begin
            busy_d[wb_rd] = 1'b0;
        end
        // Set after clear so a bypassed bundle writing wb_rd stays busy.
        if (enq && in_rd_wr) begin
            busy_d[in_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            vld_q    <= '0;
            busy_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                payload_q[i] <= '0;
                rd_q[i]      <= '0;
                rd_wr_q[i]   <= 1'b0;
            end
        end else begin
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            vld_q    <= vld_d;
            busy_q   <= busy_d;
            if (enq) begin
                payload_q[wr_ptr_q] <= in_payload;
                rd_q[wr_ptr_q]      <= in_rd;
                rd_wr_q[wr_ptr_q]   <= in_rd_wr;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_id_issue_queue.sv
`default_nettype none
// =============================================================================
// tb_id_issue_queue : self-checking bench for id_issue_queue (DEPTH 2 and 3).
// Revision: 1.0
// =============================================================================
module tb_id_issue_queue;

    localparam int PW = 32;
    localparam int RW = 5;
`ifdef ID_ISSUE_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic          v;
        logic [PW-1:0] pl;
        logic [RW-1:0] rs1;
        logic          u1;
        logic [RW-1:0] rs2;
        logic          u2;
        logic [RW-1:0] rd;
        logic          w;
        logic          wbv;
        logic [RW-1:0] wbr;
        logic          ordy;
        logic          fl;
        logic          e_ir;
        logic          e_hz;
        logic          e_ov;
        logic [1:0]    e_cnt;
        logic [PW-1:0] e_opl;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic [PW-1:0] in_payload = '0;
    logic [RW-1:0] in_rs1 = '0;
    logic [RW-1:0] in_rs2 = '0;
    logic          in_rs1_used = 1'b0;
    logic          in_rs2_used = 1'b0;
    logic [RW-1:0] in_rd = '0;
    logic          in_rd_wr = 1'b0;
    logic          out_ready = 1'b0;
    logic          wb_valid = 1'b0;
    logic [RW-1:0] wb_rd = '0;

    logic          ir2, ov2, orw2, hz2, ir3, ov3, orw3, hz3;
    logic [PW-1:0] opl2, opl3;
    logic [RW-1:0] ord2, ord3;
    logic [1:0]    cnt2, cnt3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    id_issue_queue #(.PAYLOAD_W(PW), .DEPTH(2), .NREG(32), .RADDR_W(RW)) u_d2 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir2),
        .in_payload(in_payload), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_rs1_used(in_rs1_used), .in_rs2_used(in_rs2_used), .in_rd(in_rd),
        .in_rd_wr(in_rd_wr), .out_valid(ov2), .out_ready(out_ready), .out_payload(opl2),
        .out_rd(ord2), .out_rd_wr(orw2), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .count(cnt2), .hazard(hz2));

    id_issue_queue #(.PAYLOAD_W(PW), .DEPTH(3), .NREG(32), .RADDR_W(RW)) u_d3 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir3),
        .in_payload(in_payload), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_rs1_used(in_rs1_used), .in_rs2_used(in_rs2_used), .in_rd(in_rd),
        .in_rd_wr(in_rd_wr), .out_valid(ov3), .out_ready(out_ready), .out_payload(opl3),
        .out_rd(ord3), .out_rd_wr(orw3), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .count(cnt3), .hazard(hz3));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drv(input logic v, input logic [PW-1:0] pl, input logic [RW-1:0] r1,
                       input logic u1, input logic [RW-1:0] rd, input logic w,
                       input logic wbv, input logic [RW-1:0] wbr, input logic ordy,
                       input logic fl);
        in_valid = v; in_payload = pl; in_rs1 = r1; in_rs1_used = u1;
        in_rs2 = '0; in_rs2_used = 1'b0; in_rd = rd; in_rd_wr = w;
        wb_valid = wbv; wb_rd = wbr; out_ready = ordy; flush = fl;
    endtask

    task automatic idle();
        drv(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic to_neg();
        @(negedge clk);
    endtask

    task automatic to_pos();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        to_pos();
        to_pos();
        rst_n = 1'b1;
    endtask

    function automatic vec_t mk(input int v, input int pl, input int rs1, input int u1,
                                input int rs2, input int u2, input int rd, input int w,
                                input int wbv, input int wbr, input int ordy, input int fl,
                                input int ir, input int hz, input int ov, input int cnt,
                                input int opl);
        vec_t m;
        m.v = 1'(v); m.pl = PW'(pl); m.rs1 = RW'(rs1); m.u1 = 1'(u1);
        m.rs2 = RW'(rs2); m.u2 = 1'(u2); m.rd = RW'(rd); m.w = 1'(w);
        m.wbv = 1'(wbv); m.wbr = RW'(wbr); m.ordy = 1'(ordy); m.fl = 1'(fl);
        m.e_ir = 1'(ir); m.e_hz = 1'(hz); m.e_ov = 1'(ov); m.e_cnt = 2'(cnt);
        m.e_opl = PW'(opl);
        return m;
    endfunction

    vec_t tv[19];
    logic [PW+RW-1:0] sbq[$];
    logic [PW+RW-1:0] exp_e;
    int pushed;
    int popped;
    bit pat[5];

    initial begin
        //          v  pl    rs1 u1 rs2 u2 rd w wbv wbr ordy fl | ir hz ov cnt opl
        tv[0]  = mk(0, 0,    0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0);
        tv[1]  = mk(1, 'hA1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0,   1, 0, 0, 0, 0);
        tv[2]  = mk(1, 'hB2, 0, 0, 0, 0, 6, 1, 0, 0, 0, 0,   1, 0, 1, 1, 'hA1);
        tv[3]  = mk(1, 'hC3, 0, 0, 0, 0, 8, 1, 0, 0, 0, 0,   0, 0, 1, 2, 'hA1);
        tv[4]  = mk(1, 'hC3, 0, 0, 0, 0, 8, 1, 0, 0, 1, 0,   0, 0, 1, 2, 'hA1);
        tv[5]  = mk(1, 'hC3, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 1, 1, 'hB2);
        tv[6]  = mk(1, 'hC3, 0, 0, 0, 0, 6, 1, 0, 0, 0, 0,   0, 1, 1, 1, 'hB2);
        tv[7]  = mk(0, 'hC3, 5, 1, 0, 0, 0, 0, 1, 5, 0, 0,   1, 0, 1, 1, 'hB2);
        tv[8]  = mk(1, 'hD4, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 1, 1, 'hB2);
        tv[9]  = mk(1, 'hC3, 0, 1, 0, 0, 0, 1, 0, 0, 1, 0,   0, 0, 1, 2, 'hB2);
        tv[10] = mk(1, 'hE5, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0,   1, 0, 1, 1, 'hD4);
        tv[11] = mk(1, 'hF6, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0,   1, 0, 1, 1, 'hE5);
        tv[12] = mk(1, 'hC3, 0, 0, 6, 1, 0, 0, 0, 0, 0, 0,   0, 1, 1, 2, 'hE5);
        tv[13] = mk(1, 'hC3, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1,   0, 0, 0, 2, 'hE5);
        tv[14] = mk(0, 0,    0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 'hF6);
        tv[15] = mk(1, 'hC3, 0, 0, 0, 0, 6, 1, 0, 0, 0, 0,   0, 1, 0, 0, 'hF6);
        tv[16] = mk(0, 'hC3, 0, 0, 0, 0, 0, 0, 1, 6, 0, 0,   1, 0, 0, 0, 'hF6);
        tv[17] = mk(1, 'h77, 0, 0, 0, 0, 6, 1, 0, 0, 0, 0,   1, 0, 0, 0, 'hF6);
        tv[18] = mk(0, 0,    0, 0, 0, 0, 0, 0, 0, 0, 1, 0,   1, 0, 1, 1, 'h77);

        // Reset state while rst_n is held low.
        #3;
        chk("rst_in_ready", ir2, 0);
        chk("rst_out_valid", ov2, 0);
        chk("rst_count", cnt2, 0);
        chk("rst_payload", opl2, 0);
        chk("rst_out_rd", ord2, 0);
        chk("rst_out_rd_wr", orw2, 0);
        do_reset();

        // Fill / drain / hazard / x0 / flush table on the DEPTH=2 instance.
        foreach (tv[i]) begin
            in_valid = tv[i].v; in_payload = tv[i].pl;
            in_rs1 = tv[i].rs1; in_rs1_used = tv[i].u1;
            in_rs2 = tv[i].rs2; in_rs2_used = tv[i].u2;
            in_rd = tv[i].rd; in_rd_wr = tv[i].w;
            wb_valid = tv[i].wbv; wb_rd = tv[i].wbr;
            out_ready = tv[i].ordy; flush = tv[i].fl;
            to_neg();
            chk($sformatf("v%0d_in_ready", i), ir2, tv[i].e_ir);
            chk($sformatf("v%0d_hazard", i), hz2, tv[i].e_hz);
            chk($sformatf("v%0d_out_valid", i), ov2, tv[i].e_ov);
            chk($sformatf("v%0d_count", i), cnt2, tv[i].e_cnt);
            chk($sformatf("v%0d_payload", i), opl2, tv[i].e_opl);
            to_pos();
        end

        // Drain order and pointer wrap on the DEPTH=3 instance.
        do_reset();
        pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        pushed = 0;
        popped = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (pushed == 5 && popped == 5) break;
            drv(pushed < 5, PW'(32'hD00 + pushed), '0, 1'b0, RW'(pushed + 10), 1'b0,
                1'b0, '0, (cyc < 5) ? pat[cyc] : 1'b1, 1'b0);
            to_neg();
            if (ov3 && out_ready) begin
                if (sbq.size() == 0) begin
                    chk("drain_unexpected_out", {ord3, opl3}, 0);
                end else begin
                    exp_e = sbq.pop_front();
                    chk($sformatf("drain%0d_payload", popped), opl3, exp_e[PW+RW-1:RW]);
                    chk($sformatf("drain%0d_rd", popped), ord3, exp_e[RW-1:0]);
                end
                popped++;
            end
            if (in_valid && ir3) begin
                sbq.push_back({in_payload, in_rd});
                pushed++;
            end
            to_pos();
        end
        idle();
        chk("drain_popped", popped, 5);
        chk("drain_left", sbq.size(), 0);
        to_neg();
        chk("drain_count_end", cnt3, 0);
        to_pos();

        // RAW stall released by writeback.
        do_reset();
        drv(1'b1, 32'h70, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0);
        to_neg(); chk("raw_issue_ready", ir2, 1); to_pos();
        drv(1'b1, 32'h71, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        to_neg(); chk("raw_stall1_hz", hz2, 1); chk("raw_stall1_ir", ir2, 0); to_pos();
        to_neg(); chk("raw_stall2_hz", hz2, 1); chk("raw_stall2_ir", ir2, 0); to_pos();
        wb_valid = 1'b1; wb_rd = 5'd7;
        to_neg(); chk("raw_wb_ir", ir2, BYP); chk("raw_wb_hz", hz2, !BYP); to_pos();
        wb_valid = 1'b0;
        to_neg(); chk("raw_after_ir", ir2, 1); chk("raw_after_hz", hz2, 0); to_pos();
`ifdef ID_ISSUE_WB_BYPASS_EN
        drv(1'b1, 32'h72, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0);
        to_neg(); chk("byp_setup_ir", ir2, 1); to_pos();
        drv(1'b1, 32'h73, 5'd7, 1'b1, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0);
        to_neg(); chk("byp_setwin_ir", ir2, 1); to_pos();
        drv(1'b1, 32'h74, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        to_neg(); chk("byp_setwin_hz", hz2, 1); to_pos();
`endif
        idle();

        // Flush releases queued rd bits, keeps the issued one.
        do_reset();
        drv(1'b1, 32'h90, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        to_pos();
        drv(1'b1, 32'h93, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0);
        to_neg(); chk("fl_issue_payload", opl2, 32'h90); to_pos();
        drv(1'b1, 32'h94, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        to_pos();
        drv(1'b0, '0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
        to_neg(); chk("fl_cyc_ov", ov2, 0); chk("fl_cyc_ir", ir2, 0); chk("fl_cyc_cnt", cnt2, 2); to_pos();
        idle();
        to_neg(); chk("fl_after_cnt", cnt2, 0); chk("fl_after_ov", ov2, 0); to_pos();
        drv(1'b1, 32'h1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        to_neg(); chk("fl_busy3_clear", hz2, 0); to_pos();
        drv(1'b1, 32'h2, 5'd4, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        to_neg(); chk("fl_busy4_clear", hz2, 0); to_pos();
        drv(1'b1, 32'h3, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        to_neg(); chk("fl_busy9_kept", hz2, 1); to_pos();
        idle();

        // Asynchronous reset between edges with two entries queued.
        do_reset();
        drv(1'b1, 32'hA1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        to_pos();
        drv(1'b1, 32'hB2, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        to_pos();
        idle();
        chk("ar_pre_count", cnt2, 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_out_valid", ov2, 0);
        chk("ar_count", cnt2, 0);
        chk("ar_in_ready", ir2, 0);
        chk("ar_payload", opl2, 0);
        to_pos();
        rst_n = 1'b1;
        drv(1'b1, 32'h5, 5'd6, 1'b1, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        to_neg(); chk("ar_busy_cleared", hz2, 0); to_pos();
        idle();
        to_pos();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
